// File: rtl/uart_boot_loader_if.sv
// Memory write bus between the boot loader (master) and the target memory (slave).
interface uart_boot_loader_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write;
  logic        mem_req;
  logic        mem_done;

  modport master (output mem_addr, output mem_data, output mem_write, output mem_req,
                  input  mem_done);
  modport slave  (input  mem_addr, input  mem_data, input  mem_write, input  mem_req,
                  output mem_done);
endinterface

// File: rtl/uart_boot_loader.sv
// UART 8N1 receiver plus framed image loader: A5, length (big-endian), data, checksum.
// Data bytes are written to memory through a req/done handshake.
module uart_boot_loader #(
  parameter int unsigned CLK_FREQ  = 27000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_SIZE  = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               uart_rx,
  uart_boot_loader_if.master mem,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_error
);
  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {WAIT_HDR, LEN_HI, LEN_LO, DATA, CHK, DONE} fr_state_e;

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e        rx_st_q, rx_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             stop_err_q, stop_err_d;

  fr_state_e        fr_q, fr_d;
  logic [15:0]      len_q, len_d, idx_q, idx_d, addr_q, addr_d;
  logic [7:0]       sum_q, sum_d, data_q, data_d, chk_byte_q, chk_byte_d;
  logic             chk_held_q, chk_held_d, pend_q, pend_d, req_q, req_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0]      new_len;

  assign new_len = {len_q[15:8], rx_byte_q};

  // Bit-level receiver working on the synchronised line
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    stop_err_d = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_st_d = RX_START;
        cnt_d   = '0;
      end
      RX_START: if (cnt_q == CNT_W'(HALF - 1)) begin
        cnt_d   = '0;
        bit_d   = 3'd0;
        rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end else cnt_d = cnt_q + CNT_W'(1);
      RX_DATA: if (cnt_q == CNT_W'(DIV - 1)) begin
        cnt_d   = '0;
        shift_d = {rx_s2_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_st_d = RX_STOP;
      end else cnt_d = cnt_q + CNT_W'(1);
      RX_STOP: if (cnt_q == CNT_W'(DIV - 1)) begin
        cnt_d   = '0;
        rx_st_d = RX_IDLE;
        if (rx_s2_q) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = shift_q;
        end else stop_err_d = 1'b1;
      end else cnt_d = cnt_q + CNT_W'(1);
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Frame parser, write handshake and status flags
  always_comb begin
    fr_d       = fr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    chk_held_d = chk_held_q;
    chk_byte_d = chk_byte_q;
    pend_d     = pend_q;
    req_d      = req_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
    err_d      = err_q;

    if (req_q && mem.mem_done) begin
      req_d  = 1'b0;
      pend_d = 1'b0;
    end else if (pend_q && !req_q) begin
      req_d = 1'b1;
    end

    // A held checksum is only judged once the last write has finished
    if (fr_q == CHK && chk_held_q && !pend_q) begin
      chk_held_d = 1'b0;
      if (chk_byte_q == sum_q) fr_d = DONE;
      else begin
        err_d = 1'b1;
        fr_d  = WAIT_HDR;
      end
    end

    if (stop_err_q && fr_q != DONE) begin
      err_d      = 1'b1;
      fr_d       = WAIT_HDR;
      chk_held_d = 1'b0;
    end else if (rx_valid_q) begin
      unique case (fr_q)
        WAIT_HDR: if (rx_byte_q == 8'hA5) begin
          fr_d       = LEN_HI;
          err_d      = 1'b0;
          idx_d      = '0;
          sum_d      = '0;
          chk_held_d = 1'b0;
        end
        LEN_HI: begin
          len_d = {rx_byte_q, 8'h00};
          fr_d  = LEN_LO;
        end
        LEN_LO: begin
          len_d = new_len;
          if (32'(new_len) > MAX_SIZE) begin
            err_d = 1'b1;
            fr_d  = WAIT_HDR;
          end else if (new_len == 16'd0) fr_d = CHK;
          else fr_d = DATA;
        end
        DATA: if (pend_q) begin
          err_d = 1'b1;
          fr_d  = WAIT_HDR;
        end else begin
          data_d = rx_byte_q;
          addr_d = BASE_ADDR + idx_q;
          pend_d = 1'b1;
          sum_d  = sum_q + rx_byte_q;
          idx_d  = idx_q + 16'd1;
          if (idx_q + 16'd1 == len_q) fr_d = CHK;
        end
        CHK: if (!chk_held_q) begin
          chk_held_d = 1'b1;
          chk_byte_d = rx_byte_q;
        end
        default: ;
      endcase
    end

    done_d = done_q | (fr_d == DONE);
    busy_d = (fr_d inside {LEN_HI, LEN_LO, DATA, CHK}) | pend_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      stop_err_q <= 1'b0;
      fr_q       <= WAIT_HDR;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      chk_held_q <= 1'b0;
      chk_byte_q <= '0;
      pend_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      stop_err_q <= stop_err_d;
      fr_q       <= fr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      chk_held_q <= chk_held_d;
      chk_byte_q <= chk_byte_d;
      pend_q     <= pend_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_data  = data_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_write = req_q;
  assign load_busy     = busy_q;
  assign load_done     = done_q;
  assign load_error    = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames plus random frames against a frame-level model.
module tb_uart_boot_loader;
  localparam int unsigned DIV  = 16;
  localparam int unsigned MAXN = 8;
  localparam logic [15:0] BASE = 16'h0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic load_busy, load_done, load_error;

  uart_boot_loader_if bus();

  uart_boot_loader #(.CLK_FREQ(160), .BAUD(10), .BASE_ADDR(BASE), .MAX_SIZE(MAXN)) dut (
    .clock(clock), .reset(reset), .uart_rx(uart_rx), .mem(bus),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error));

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int lat = 3;
  int wcnt = 0;
  bit acked = 1'b0;
  int req_rises = 0;
  int stab_err = 0;
  int wbase = 0;
  int rbase = 0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  logic [15:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  // Memory responder: mem_done one cycle, lat cycles after mem_req rises; logs every write
  always @(negedge clock) begin
    bus.mem_done = 1'b0;
    if (bus.mem_write !== bus.mem_req) stab_err++;
    if (bus.mem_req && prev_req && (bus.mem_addr !== prev_addr || bus.mem_data !== prev_data))
      stab_err++;
    if (bus.mem_req && !prev_req) req_rises++;
    if (!bus.mem_req) begin
      wcnt  = 0;
      acked = 1'b0;
    end else if (!acked) begin
      wcnt++;
      if (wcnt >= lat) begin
        bus.mem_done = 1'b1;
        acked = 1'b1;
        wlog_a.push_back(bus.mem_addr);
        wlog_d.push_back(bus.mem_data);
      end
    end
    prev_req  = bus.mem_req;
    prev_addr = bus.mem_addr;
    prev_data = bus.mem_data;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clock);
    uart_rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(DIV);
    end
    uart_rx = stop_ok;
    tick(DIV);
    uart_rx = 1'b1;
    tick(DIV);
  endtask

  task automatic send_frame(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
    wbase = wlog_a.size();
    rbase = req_rises;
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    tick(30);
    while (load_busy && n < 2000) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, 32'(load_busy), 32'd0);
  endtask

  task automatic check_writes(input string tag, input logic [15:0] ea[$], input logic [7:0] ed[$]);
    check({tag, "_nwr"}, 32'(wlog_a.size() - wbase), 32'(ea.size()));
    for (int i = 0; i < ea.size() && wbase + i < wlog_a.size(); i++) begin
      check({tag, "_addr"}, 32'(wlog_a[wbase+i]), 32'(ea[i]));
      check({tag, "_data"}, 32'(wlog_d[wbase+i]), 32'(ed[i]));
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_done, input logic exp_err);
    check({tag, "_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_err"}, 32'(load_error), 32'(exp_err));
  endtask

  logic [7:0]  fr[$];
  logic [15:0] ea[$];
  logic [7:0]  ed[$];

  initial begin
    int n, s;
    logic [15:0] len;
    logic [7:0] b, chk;
    logic m_done, m_err;

    // Reset values
    #1 reset = 1'b0;
    tick(3);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_write", 32'(bus.mem_write), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_data", 32'(bus.mem_data), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check_flags("rst", 1'b0, 1'b0);
    reset = 1'b1;
    tick(2);
    wbase = wlog_a.size();
    rbase = req_rises;

    // Good frame
    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_frame(fr);
    settle("good");
    ea = '{16'h0000, 16'h0001, 16'h0002};
    ed = '{8'h11, 8'h22, 8'h33};
    check_writes("good", ea, ed);
    check_flags("good", 1'b1, 1'b0);
    tick(200);
    check("good_nreq", 32'(req_rises - rbase), 32'd3);

    // Bad checksum, then recovery with a good frame
    do_reset();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'hFF};
    send_frame(fr);
    settle("badchk");
    check_flags("badchk", 1'b0, 1'b1);
    fr = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'h5A};
    send_frame(fr);
    settle("recover");
    ea = '{16'h0000, 16'h0001, 16'h0000};
    ed = '{8'h01, 8'h02, 8'h5A};
    check_writes("recover", ea, ed);
    check_flags("recover", 1'b1, 1'b0);

    // Oversize and length boundary
    do_reset();
    fr = '{8'hA5, 8'h01, 8'h01};
    send_frame(fr);
    settle("over");
    ea = '{};
    ed = '{};
    check_writes("over", ea, ed);
    check_flags("over", 1'b0, 1'b1);
    fr = '{8'hA5, 8'h00, 8'h09};
    send_frame(fr);
    settle("over9");
    check_writes("over9", ea, ed);
    check_flags("over9", 1'b0, 1'b1);

    // Zero length
    do_reset();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(fr);
    settle("zero");
    check_writes("zero", ea, ed);
    check_flags("zero", 1'b1, 1'b0);

    // Stop bit low on the second data byte aborts the frame
    do_reset();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h11};
    send_frame(fr);
    send_byte(8'h22, 1'b0);
    settle("stop");
    check_flags("stop", 1'b0, 1'b1);
    fr = '{8'h33, 8'h44};
    send_frame(fr);
    settle("stop2");
    ea = '{16'h0000};
    ed = '{8'h11};
    check_writes("stop", ea, ed);
    check_flags("stop2", 1'b0, 1'b1);

    // Short low glitch between header and length must not produce a byte
    do_reset();
    send_byte(8'hA5, 1'b1);
    @(negedge clock);
    uart_rx = 1'b0;
    tick(5);
    uart_rx = 1'b1;
    tick(100);
    fr = '{8'h00, 8'h01, 8'h7E, 8'h7E};
    send_frame(fr);
    settle("glitch");
    ea = '{16'h0000};
    ed = '{8'h7E};
    check_writes("glitch", ea, ed);
    check_flags("glitch", 1'b1, 1'b0);

    // Reset during the second write with mem_req high
    do_reset();
    lat = 20;
    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    send_frame(fr);
    n = 0;
    while (!(bus.mem_req && req_rises - rbase == 2) && n < 200) begin
      tick(1);
      n++;
    end
    check("rst_mid_req_seen", 32'(bus.mem_req && (req_rises - rbase == 2)), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_write", 32'(bus.mem_write), 32'd0);
    check("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mid_busy", 32'(load_busy), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(2);
    lat = 3;
    wbase = wlog_a.size();
    fr = '{8'hA5, 8'h00, 8'h03, 8'hC1, 8'hC2, 8'hC3, 8'h46};
    send_frame(fr);
    settle("after_rst");
    ea = '{16'h0000, 16'h0001, 16'h0002};
    ed = '{8'hC1, 8'hC2, 8'hC3};
    check_writes("after_rst", ea, ed);
    check_flags("after_rst", 1'b1, 1'b0);

    // Overrun: second data byte arrives while the first write is pending
    do_reset();
    lat = 200;
    fr = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    send_frame(fr);
    tick(10);
    check("ovr_err_early", 32'(load_error), 32'd1);
    settle("ovr");
    ea = '{16'h0000};
    ed = '{8'h11};
    check_writes("ovr", ea, ed);
    check_flags("ovr", 1'b0, 1'b1);

    // Random frames against the frame-level model
    for (int t = 0; t < 6; t++) begin
      do_reset();
      lat = $urandom_range(1, 8);
      fr = '{};
      ea = '{};
      ed = '{};
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        fr.push_back(b);
      end
      fr.push_back(8'hA5);
      if ($urandom_range(0, 3) == 0) len = 16'($urandom_range(MAXN + 1, 300));
      else len = 16'($urandom_range(0, MAXN));
      fr.push_back(len[15:8]);
      fr.push_back(len[7:0]);
      m_done = 1'b0;
      m_err = 1'b0;
      if (32'(len) > MAXN) m_err = 1'b1;
      else begin
        s = 0;
        for (int i = 0; i < int'(len); i++) begin
          b = 8'($urandom);
          fr.push_back(b);
          ea.push_back(BASE + 16'(i));
          ed.push_back(b);
          s += int'(b);
        end
        chk = ($urandom_range(0, 1) == 1) ? 8'(s % 256) : 8'($urandom);
        fr.push_back(chk);
        if (int'(chk) == s % 256) m_done = 1'b1;
        else m_err = 1'b1;
      end
      send_frame(fr);
      settle("rnd");
      check_writes("rnd", ea, ed);
      check_flags("rnd", m_done, m_err);
    end

    check("bus_stable", 32'(stab_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameters SHALL be: CLK_FREQ, default 27000000, clock rate in Hz; BAUD, default 115200, UART bit rate; BASE_ADDR, default 16'h0000, first memory write address; MAX_SIZE, default 256, maximum payload length in bytes.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  single system clock; one clock, all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input; idles high; 8N1 format.
- mem_addr  out  16  write address.
- mem_data  out  8  write data.
- mem_write  out  1  write strobe; high whenever mem_req is high.
- mem_req  out  1  memory request.
- mem_done  in  1  memory completion for the current request.
- load_busy  out  1  a frame is in progress, from header accepted to end of checksum.
- load_done  out  1  sticky; image loaded and checksum good; releases the core.
- load_error  out  1  sticky error flag; cleared when the next header is accepted.

Function
REQ-003 uart_rx SHALL pass through a 2-flop synchroniser before any use.
REQ-004 The bit divisor SHALL be DIV = CLK_FREQ/BAUD, using integer truncation.
- A falling edge in RX_IDLE starts the receiver.
- The start bit is re-sampled at DIV/2; if it is high, the receiver returns to RX_IDLE with no byte.
- The 8 data bits (LSB first) are then sampled every DIV cycles, followed by the stop bit.
REQ-005 A stop bit sampled low SHALL discard the byte, set load_error, and return the frame FSM to WAIT_HDR.
REQ-006 A good byte SHALL produce a one-cycle rx_valid pulse, issued in the cycle after the stop-bit sample.
REQ-007 Frame FSM states and transitions SHALL be:
- WAIT_HDR: byte 0xA5 -> LEN_HI; any other byte is ignored.
- LEN_HI -> LEN_LO.
- LEN_LO: length N (big-endian) > MAX_SIZE -> set load_error, go to WAIT_HDR.
- LEN_LO: N == 0 -> CHK.
- LEN_LO: otherwise -> DATA.
- DATA: after the N-th byte -> CHK.
- CHK: checksum byte equal to the 8-bit modulo-256 sum of the data bytes -> DONE; otherwise set load_error and go to WAIT_HDR.
- DONE is terminal until reset; received bytes are ignored.
REQ-008 Accepting 0xA5 in WAIT_HDR SHALL clear load_error, the byte index, and the running sum.
REQ-009 Each DATA byte SHALL be written to a 1-byte holding register, and its write SHALL be issued at address BASE_ADDR + index.
- The address is computed in 16 bits and wraps modulo 2^16.
REQ-010 Write handshake:
- Raise mem_req in the cycle after the byte is latched.
- Hold mem_addr, mem_data and mem_write stable while mem_req is high.
- Deassert mem_req in the cycle after mem_done is sampled high.
- Keep mem_req low for at least 1 cycle before the next request.
- mem_done sampled while mem_req is low is ignored.
REQ-011 If a DATA byte arrives while the previous write is still pending, the new byte SHALL be dropped, load_error set, and the FSM go to WAIT_HDR.
- The pending write still completes its handshake.
REQ-012 CHK SHALL NOT transition to DONE until the last write's handshake has completed.
- A checksum byte arriving before that completion is held until it completes.
REQ-013 load_done SHALL rise in the cycle DONE is entered and stay high until reset.
REQ-014 load_busy SHALL be high in LEN_HI, LEN_LO, DATA and CHK, and while any write is pending.

Reset
REQ-015 Asserting reset low SHALL asynchronously force the following, regardless of state, including mid-byte and mid-handshake:
- RX_IDLE and WAIT_HDR.
- mem_req=0, mem_write=0, mem_addr=0, mem_data=0.
- load_busy=0, load_done=0, load_error=0.
- Synchroniser flops = 1.
- All counters and the running sum = 0.
REQ-016 After reset deasserts, the block SHALL wait for a new header and SHALL NOT resume any prior frame.

Verification (CLK_FREQ=160, BAUD=10, DIV=16; memory model with mem_done 3 cycles after mem_req)
REQ-017 Good frame: A5 00 03 11 22 33 66 -> writes (0000,11), (0001,22), (0002,33) in order; load_done=1; load_error=0; no further mem_req.
REQ-018 Bad checksum: A5 00 02 01 02 FF -> 2 writes; load_error=1; load_done=0; a following good frame clears load_error and sets load_done.
REQ-019 Oversize and zero length:
- A5 01 01 -> load_error=1, no writes.
- A5 00 00 00 -> load_done=1, no writes.
REQ-020 Line errors:
- Stop bit forced low on the 2nd data byte -> load_error=1, frame aborted.
- A 5-cycle low glitch on uart_rx -> no byte.
REQ-021 Reset mid-operation: assert reset during the 2nd write with mem_req high -> mem_req=0 immediately (asynchronously); a subsequent full frame loads correctly from BASE_ADDR.
REQ-022 Overrun: memory model with mem_done 200 cycles after mem_req -> 2nd data byte dropped, load_error=1, 1st write completes.
